// File: rtl/branch_predict_gshare_ckpt_pkg.sv
// Shared constants and helpers for the checkpointed gshare predictor.
// Counter-state values are functions of the counter width because the
// width is a parameter of the top module.
package branch_predict_gshare_ckpt_pkg;

    // Counter value that predicts "taken" with the least confidence.
    function automatic int ctrWeakT(input int ctrWidth);
        return 1 << (ctrWidth - 1);
    endfunction

    // Largest value a counter can hold.
    function automatic int ctrMax(input int ctrWidth);
        return (1 << ctrWidth) - 1;
    endfunction

    // Smallest value a counter can hold.
    localparam int CTR_MIN = 0;

    // Single-bit payload fields.
    localparam int PAY_VALID_BITS = 1;
    localparam int PAY_PRED_BITS  = 1;

    // Packed payload layout, MSB first: {valid, pred, index, ghrSnap}.
    function automatic int payloadWidth(input int phtDepth, input int ghrLen);
        return PAY_VALID_BITS + PAY_PRED_BITS + phtDepth + ghrLen;
    endfunction

endpackage

// File: rtl/branch_predict_gshare_ckpt_stage_reg.sv
// Pipeline payload register for one stage (D, E or M).
// A flush clears the payload and wins over a stall; a stall holds it.
module bp_stage_reg
    import branch_predict_gshare_ckpt_pkg::*;
#(
    parameter int WIDTH = payloadWidth(6, 6)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] payloadQ;

    // Payload register: async reset, then sync clear, then enabled load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            payloadQ <= '0;
        end else if (clear) begin
            payloadQ <= '0;
        end else if (enable) begin
            payloadQ <= d;
        end
    end

    assign q = payloadQ;

endmodule

// File: rtl/branch_predict_gshare_ckpt.sv
// Gshare branch predictor with a per-branch history checkpoint.
// Each in-flight branch carries the speculative history it saw in F, so a
// mispredict in M restores the history exactly. The PHT is trained with the
// index captured in F, never a recomputed one.
module branch_predict_gshare_ckpt
    import branch_predict_gshare_ckpt_pkg::*;
#(
    parameter int PHT_DEPTH  = 6,
    parameter int GHR_LEN    = 6,
    parameter int CTR_WIDTH  = 2,
    parameter int PERF_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stallF,
    input  logic                  stallD,
    input  logic                  stallE,
    input  logic                  stallM,
    input  logic                  flushD,
    input  logic                  flushE,
    input  logic                  flushM,
    input  logic [31:0]           pcF,
    input  logic                  branchF,
    input  logic                  branchM,
    input  logic                  actual_takeM,
    output logic                  pred_takeD,
    output logic [PHT_DEPTH-1:0]  PHT_index,
    output logic [PHT_DEPTH-1:0]  update_PHT_index,
    output logic                  correct,
    output logic                  mispredictM,
    output logic [PERF_WIDTH-1:0] perf_branch_cnt,
    output logic [PERF_WIDTH-1:0] perf_mispred_cnt
);

    localparam int PW        = payloadWidth(PHT_DEPTH, GHR_LEN);
    localparam int PHT_ROWS  = 1 << PHT_DEPTH;
    localparam logic [CTR_WIDTH-1:0] CTR_WEAK_T = CTR_WIDTH'(ctrWeakT(CTR_WIDTH));
    localparam logic [CTR_WIDTH-1:0] CTR_MAX    = CTR_WIDTH'(ctrMax(CTR_WIDTH));
    localparam logic [CTR_WIDTH-1:0] CTR_FLOOR  = CTR_WIDTH'(CTR_MIN);

    logic [CTR_WIDTH-1:0]  phtQ [PHT_ROWS];
    logic [GHR_LEN-1:0]    ghrSpecQ;
    logic [GHR_LEN-1:0]    ghrSpecD;
    logic [GHR_LEN-1:0]    ghrRetireQ;
    logic [PERF_WIDTH-1:0] perfBranchQ;
    logic [PERF_WIDTH-1:0] perfMispredQ;

    logic [PHT_DEPTH-1:0]  ghrExt;
    logic [PHT_DEPTH-1:0]  indexF;
    logic                  predTakeF;
    logic [PW-1:0]         payF;
    logic [PW-1:0]         payD;
    logic [PW-1:0]         payE;
    logic [PW-1:0]         payM;

    logic                  predD;
    logic                  validM;
    logic                  predM;
    logic [PHT_DEPTH-1:0]  indexM;
    logic [GHR_LEN-1:0]    snapM;
    logic                  retireM;
    logic                  correctM;
    logic                  mispredM;

    // Saturating counter step; the MSB of the result is the taken threshold.
    function automatic logic [CTR_WIDTH-1:0] satUpdate(input logic [CTR_WIDTH-1:0] ctr,
                                                       input logic taken);
        if (taken) begin
            return (ctr == CTR_MAX) ? ctr : ctr + CTR_WIDTH'(1);
        end
        return (ctr == CTR_FLOOR) ? ctr : ctr - CTR_WIDTH'(1);
    endfunction

    // History is zero-extended into the low index bits before the XOR.
    assign ghrExt    = PHT_DEPTH'(ghrSpecQ);
    assign indexF    = pcF[PHT_DEPTH+1:2] ^ ghrExt;
    assign predTakeF = branchF & phtQ[indexF][CTR_WIDTH-1];
    assign payF      = {branchF, predTakeF, indexF, ghrSpecQ};

    bp_stage_reg #(.WIDTH(PW)) stageD (
        .clk    (clk),
        .rst    (rst),
        .clear  (flushD),
        .enable (~stallD),
        .d      (payF),
        .q      (payD)
    );

    bp_stage_reg #(.WIDTH(PW)) stageE (
        .clk    (clk),
        .rst    (rst),
        .clear  (flushE),
        .enable (~stallE),
        .d      (payD),
        .q      (payE)
    );

    bp_stage_reg #(.WIDTH(PW)) stageM (
        .clk    (clk),
        .rst    (rst),
        .clear  (flushM),
        .enable (~stallM),
        .d      (payE),
        .q      (payM)
    );

    assign predD    = payD[PW-2];
    assign validM   = payM[PW-1];
    assign predM    = payM[PW-2];
    assign indexM   = payM[PW-3 -: PHT_DEPTH];
    assign snapM    = payM[GHR_LEN-1:0];

    assign correctM = (predM == actual_takeM);
    assign mispredM = branchM & validM & ~correctM;
    assign retireM  = branchM & validM & ~stallM;

    // Next speculative history: a resolved mispredict rebuilds it from the
    // checkpoint and discards any same-cycle wrong-path F update.
    always_comb begin
        ghrSpecD = ghrSpecQ;
        if (mispredM && !stallM) begin
            ghrSpecD = {snapM[GHR_LEN-2:0], actual_takeM};
        end else if (branchF && !stallF) begin
            ghrSpecD = {ghrSpecQ[GHR_LEN-2:0], predTakeF};
        end
    end

    // Speculative history register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghrSpecQ <= '0;
        end else begin
            ghrSpecQ <= ghrSpecD;
        end
    end

    // Retired history, kept for debug observation only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghrRetireQ <= '0;
        end else if (retireM) begin
            ghrRetireQ <= {ghrRetireQ[GHR_LEN-2:0], actual_takeM};
        end
    end

    // PHT training at the index captured in F; F reads the pre-write value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PHT_ROWS; i++) begin
                phtQ[i] <= CTR_WEAK_T;
            end
        end else if (retireM) begin
            phtQ[indexM] <= satUpdate(phtQ[indexM], actual_takeM);
        end
    end

    // Retirement performance counters, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perfBranchQ  <= '0;
            perfMispredQ <= '0;
        end else if (retireM) begin
            if (perfBranchQ != '1) begin
                perfBranchQ <= perfBranchQ + PERF_WIDTH'(1);
            end
            if (mispredM && perfMispredQ != '1) begin
                perfMispredQ <= perfMispredQ + PERF_WIDTH'(1);
            end
        end
    end

    // PC bits outside the index window and the debug history feed no output.
    logic unusedBits;
    assign unusedBits = ^{pcF[31:PHT_DEPTH+2], pcF[1:0], ghrRetireQ};

    assign pred_takeD       = predD;
    assign PHT_index        = indexF;
    assign update_PHT_index = indexM;
    assign correct          = correctM;
    assign mispredictM      = mispredM;
    assign perf_branch_cnt  = perfBranchQ;
    assign perf_mispred_cnt = perfMispredQ;

endmodule
